opcode_assembler_fifo: RTL and testbench



---
 rtl/gpu_pkg.sv | 15 +
 rtl/opcode_sync_fifo.sv | 53 +++++
 rtl/opcode_assembler_fifo.sv | 69 ++++++
 tb/tb_opcode_assembler_fifo.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: opcode widths and decode field offsets shared by the command path and the core
package gpu_pkg;
    localparam int CMD_WORD_W = 32;
    localparam int OPCODE_W   = 96;
    typedef logic [OPCODE_W-1:0] opcode_t;
    // Decode fields, MSB-first to match the order words arrive on the bus
    localparam int OP_CODE_W   = 8;
    localparam int OP_CODE_LSB = OPCODE_W - OP_CODE_W;
    localparam int OP_DST_W    = 8;
    localparam int OP_DST_LSB  = OP_CODE_LSB - OP_DST_W;
    localparam int OP_SRC_W    = 16;
    localparam int OP_SRC_LSB  = OP_DST_LSB - OP_SRC_W;
    localparam int OP_IMM_W    = 64;
    localparam int OP_IMM_LSB  = 0;
endpackage

// File: rtl/opcode_sync_fifo.sv
// opcode_sync_fifo: show-ahead FIFO whose registered head output holds its last value when empty
module opcode_sync_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          valid
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] cnt_nxt;
    logic [W-1:0]  head_nxt;
    logic          do_push, do_pop;

    assign full     = count == CW'(DEPTH);
    assign valid    = count != '0;
    assign do_push  = push && !full && !clr;
    assign do_pop   = pop && valid && !clr;
    assign rd_nxt   = rd_ptr + PW'(do_pop);
    assign cnt_nxt  = count + CW'(do_push) - CW'(do_pop);
    // A push into an empty FIFO becomes the head directly, bypassing storage
    assign head_nxt = (do_push && wr_ptr == rd_nxt) ? din : mem[rd_nxt];

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            if (cnt_nxt != '0) dout <= head_nxt;
        end
endmodule

// File: rtl/opcode_assembler_fifo.sv
// opcode_assembler_fifo: packs bus command words MSB-first into opcodes and queues them for the core
module opcode_assembler_fifo
    import gpu_pkg::*;
#(
    parameter int WORD_W       = CMD_WORD_W,
    parameter int WORDS_PER_OP = 3,
    parameter int DEPTH        = 4,
    localparam int OP_W        = WORD_W * WORDS_PER_OP,
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int NW          = WORDS_PER_OP > 1 ? $clog2(WORDS_PER_OP) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              flush,
    output logic              op_valid,
    output logic [OP_W-1:0]   op_data,
    input  logic              op_ready,
    output logic [CW-1:0]     op_count,
    output logic              partial,
    output logic              overflow
);
    logic [NW-1:0]   word_cnt;
    logic [OP_W-1:0] asm_q, asm_nxt;
    logic            last, accept, fifo_full;

    assign last     = word_cnt == NW'(WORDS_PER_OP - 1);
    // Only registered state gates readiness, so a same-cycle pop cannot admit a completing word
    assign wr_ready = !(fifo_full && last);
    assign accept   = wr_en && wr_ready;
    assign partial  = word_cnt != '0;

    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[OP_W-1-int'(word_cnt)*WORD_W -: WORD_W] = wr_data;
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            word_cnt <= '0;
            asm_q    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            word_cnt <= '0;
            asm_q    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                word_cnt <= last ? '0 : word_cnt + NW'(1);
                asm_q    <= last ? '0 : asm_nxt;
            end
            if (wr_en && !wr_ready) overflow <= 1'b1;
        end

    opcode_sync_fifo #(.W(OP_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (flush),
        .push  (accept && last),
        .din   (asm_nxt),
        .pop   (op_ready),
        .dout  (op_data),
        .count (op_count),
        .full  (fifo_full),
        .valid (op_valid)
    );
endmodule

// File: tb/tb_opcode_assembler_fifo.sv
// tb_opcode_assembler_fifo: directed checks of assembly order, backpressure, flush and reset
module tb_opcode_assembler_fifo;
    import gpu_pkg::*;

    logic        clk, n_rst, wr_en, wr_ready, flush, op_valid, op_ready, partial, overflow;
    logic [31:0] wr_data;
    opcode_t     op_data;
    logic [2:0]  op_count;
    int          checks, errors;
    opcode_t     q[$];

    opcode_assembler_fifo dut (
        .clk(clk), .n_rst(n_rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready),
        .flush(flush), .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
        .op_count(op_count), .partial(partial), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic opcode_t op_of(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return {a, b, c};
    endfunction

    function automatic logic [31:0] w(input int o, input int j);
        return {16'(o), 16'(j)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d);
        wr_en = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pop_one();
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #12;
        checks += 6;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
        if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid: got %b expected 0", op_valid); end
        if (op_count !== 3'd0) begin errors++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
        if (partial !== 1'b0) begin errors++; $display("FAIL reset_partial: got %b expected 0", partial); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        if (op_data !== '0) begin errors++; $display("FAIL reset_op_data: got %h expected 0", op_data); end
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        opcode_t exp;
        exp = op_of(32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003);
        wr(32'hAAAA0001);
        checks++;
        if (partial !== 1'b1) begin errors++; $display("FAIL single_partial1: got %b expected 1", partial); end
        wr(32'hBBBB0002);
        checks += 2;
        if (partial !== 1'b1) begin errors++; $display("FAIL single_partial2: got %b expected 1", partial); end
        if (op_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", op_valid); end
        wr(32'hCCCC0003);
        checks += 4;
        if (op_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", op_valid); end
        if (op_data !== exp) begin errors++; $display("FAIL single_data: got %h expected %h", op_data, exp); end
        if (op_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", op_count); end
        if (partial !== 1'b0) begin errors++; $display("FAIL single_partial3: got %b expected 0", partial); end
        pop_one();
        checks += 3;
        if (op_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", op_valid); end
        if (op_count !== 3'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", op_count); end
        if (op_data !== exp) begin errors++; $display("FAIL single_hold_data: got %h expected %h", op_data, exp); end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        checks++;
        if (op_count !== 3'd0) begin errors++; $display("FAIL single_idle_pop: got %0d expected 0", op_count); end
    endtask

    task automatic test_overflow();
        opcode_t exp;
        for (int i = 0; i < 14; i++) wr(32'h100 + 32'(i));
        checks += 4;
        if (op_count !== 3'd4) begin errors++; $display("FAIL ovf_count_full: got %0d expected 4", op_count); end
        if (partial !== 1'b1) begin errors++; $display("FAIL ovf_partial: got %b expected 1", partial); end
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL ovf_wr_ready: got %b expected 0", wr_ready); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
        wr(32'hDEAD0000);
        checks += 3;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        if (op_count !== 3'd4) begin errors++; $display("FAIL ovf_count_kept: got %0d expected 4", op_count); end
        if (partial !== 1'b1) begin errors++; $display("FAIL ovf_partial_kept: got %b expected 1", partial); end
        exp = op_of(32'h100, 32'h101, 32'h102);
        checks++;
        if (op_data !== exp) begin errors++; $display("FAIL ovf_head0: got %h expected %h", op_data, exp); end
        pop_one();
        checks += 2;
        if (op_count !== 3'd3) begin errors++; $display("FAIL ovf_count_pop: got %0d expected 3", op_count); end
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_reopen: got %b expected 1", wr_ready); end
        wr(32'hABCD0000);
        checks += 2;
        if (op_count !== 3'd4) begin errors++; $display("FAIL ovf_refill: got %0d expected 4", op_count); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        for (int k = 1; k < 4; k++) begin
            exp = op_of(32'h100 + 32'(3 * k), 32'h101 + 32'(3 * k), 32'h102 + 32'(3 * k));
            checks++;
            if (op_data !== exp) begin errors++; $display("FAIL ovf_order%0d: got %h expected %h", k, op_data, exp); end
            pop_one();
        end
        exp = op_of(32'h10C, 32'h10D, 32'hABCD0000);
        checks += 2;
        if (op_data !== exp) begin errors++; $display("FAIL ovf_dropped_word: got %h expected %h", op_data, exp); end
        if (op_count !== 3'd1) begin errors++; $display("FAIL ovf_last_count: got %0d expected 1", op_count); end
        pop_one();
    endtask

    task automatic test_flush();
        opcode_t exp;
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL flush_pre_overflow: got %b expected 1", overflow); end
        wr(32'h11111111);
        wr(32'h22222222);
        wr(32'h33333333);
        wr(32'h44444444);
        wr_en = 1'b1;
        wr_data = 32'h55555555;
        flush = 1'b1;
        step();
        wr_en = 1'b0;
        flush = 1'b0;
        checks += 4;
        if (partial !== 1'b0) begin errors++; $display("FAIL flush_partial: got %b expected 0", partial); end
        if (op_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", op_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b expected 0", overflow); end
        if (op_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", op_valid); end
        wr(32'h66666666);
        wr(32'h77777777);
        wr(32'h88888888);
        exp = op_of(32'h66666666, 32'h77777777, 32'h88888888);
        checks += 2;
        if (op_data !== exp) begin errors++; $display("FAIL flush_fresh: got %h expected %h", op_data, exp); end
        if (op_count !== 3'd1) begin errors++; $display("FAIL flush_fresh_count: got %0d expected 1", op_count); end
    endtask

    task automatic test_back_to_back();
        do_flush();
        q.delete();
        for (int o = 0; o < 2; o++) begin
            for (int j = 0; j < 3; j++) wr(w(o, j));
            q.push_back(op_of(w(o, 0), w(o, 1), w(o, 2)));
        end
        for (int o = 2; o < 14; o++) begin
            wr(w(o, 0));
            wr(w(o, 1));
            checks += 3;
            if (op_count !== 3'(q.size())) begin errors++; $display("FAIL b2b_count_pre%0d: got %0d expected %0d", o, op_count, q.size()); end
            if (partial !== 1'b1) begin errors++; $display("FAIL b2b_partial%0d: got %b expected 1", o, partial); end
            if (op_data !== q[0]) begin errors++; $display("FAIL b2b_head%0d: got %h expected %h", o, op_data, q[0]); end
            wr_en = 1'b1;
            wr_data = w(o, 2);
            op_ready = 1'b1;
            step();
            wr_en = 1'b0;
            op_ready = 1'b0;
            void'(q.pop_front());
            q.push_back(op_of(w(o, 0), w(o, 1), w(o, 2)));
            checks += 2;
            if (op_count !== 3'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d expected 2", o, op_count); end
            if (op_data !== q[0]) begin errors++; $display("FAIL b2b_next%0d: got %h expected %h", o, op_data, q[0]); end
        end
        while (q.size() > 0) begin
            checks++;
            if (op_data !== q[0]) begin errors++; $display("FAIL b2b_drain: got %h expected %h", op_data, q[0]); end
            void'(q.pop_front());
            pop_one();
        end
        checks++;
        if (op_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", op_valid); end
    endtask

    task automatic test_async_reset();
        opcode_t exp;
        for (int i = 0; i < 10; i++) wr(32'h200 + 32'(i));
        checks += 2;
        if (op_count !== 3'd3) begin errors++; $display("FAIL arst_pre_count: got %0d expected 3", op_count); end
        if (partial !== 1'b1) begin errors++; $display("FAIL arst_pre_partial: got %b expected 1", partial); end
        #3;
        n_rst = 1'b0;
        #1;
        checks += 6;
        if (op_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b expected 0", op_valid); end
        if (op_count !== 3'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", op_count); end
        if (partial !== 1'b0) begin errors++; $display("FAIL arst_partial: got %b expected 0", partial); end
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL arst_wr_ready: got %b expected 1", wr_ready); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL arst_overflow: got %b expected 0", overflow); end
        if (op_data !== '0) begin errors++; $display("FAIL arst_data: got %h expected 0", op_data); end
        #12;
        n_rst = 1'b1;
        step();
        step();
        wr(32'h300);
        wr(32'h301);
        checks += 2;
        if (op_valid !== 1'b0) begin errors++; $display("FAIL arst_residual: got %b expected 0", op_valid); end
        if (partial !== 1'b1) begin errors++; $display("FAIL arst_new_partial: got %b expected 1", partial); end
        wr(32'h302);
        exp = op_of(32'h300, 32'h301, 32'h302);
        checks += 2;
        if (op_data !== exp) begin errors++; $display("FAIL arst_new_op: got %h expected %h", op_data, exp); end
        if (op_count !== 3'd1) begin errors++; $display("FAIL arst_new_count: got %0d expected 1", op_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_rst = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        flush = 1'b0;
        op_ready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
